// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg: shared control encodings for the RV32I multicycle sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage : riscv_ctrl_pkg

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder: ALUOp/funct3/funct7b5/op[5] -> ALUControl (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [1:0]            alu_op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    input  logic                  op5_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o
);

    logic [2:0] ctrl;

    always_comb begin
        ctrl = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only selects sub for register-register ops
                    3'b000:  ctrl = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  ctrl = ALU_SLT;
                    3'b110:  ctrl = ALU_OR;
                    3'b111:  ctrl = ALU_AND;
                    default: ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    assign alu_control_o = ALU_CTRL_W'(ctrl);

endmodule : alu_decoder

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// multicycle_control_fsm: Moore control sequencer for the multicycle RV32I core
// Optional feature: ILLEGAL_TRAP_EN adds an ERROR state and the illegal port.
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W    = 4,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [STATE_W-1:0]    state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                  illegal
`endif
);

    state_t     state_q, state_d;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_ERROR;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_ERROR:    state_d = S_ERROR;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
`ifdef ILLEGAL_TRAP_EN
        illegal   = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_ERROR: illegal = 1'b1;
`endif
            default: ;
        endcase

        PCWrite = pc_update | (branch & zero);

        // Strobes are killed during reset so an abandoned access never completes
        if (!rst) begin
            mem_req  = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    assign state_o = STATE_W'(state_q);

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (ALUControl)
    );

endmodule : multicycle_control_fsm

`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control sequencer for the multicycle variant of the RV32I core.
- It supplies the PCSrc/immSrc-style control that the current datapath drives from temporary test inputs. It also adds register-file, memory and ALU control.
- Moore FSM over instruction phases: fetch, decode, execute, memory, writeback. Includes an ALU-control decoder and a memory-ready handshake.
- Sits between the instruction register fields (op, funct3, funct7b5), the ALU zero flag and the shared instruction/data memory.

Parameters:
- STATE_W, 4, width of state register and debug state output.
- ALU_CTRL_W, 3, width of ALUControl.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE).
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  instruction register and OldPC enable.
- RegWrite  out  1  register file write (WE3).
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immExt, 10 = constant 4.
- ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
- state_o  out  STATE_W  current state, for debug and verification.
- illegal  out  1  illegal opcode flag; only exists with the optional feature.

Behaviour:
- Reset:
  - rst low asynchronously forces state to FETCH.
  - While rst is low, PCWrite, IRWrite, MemWrite, RegWrite and mem_req are 0.
  - Reset mid-instruction abandons that instruction; no partial write is issued.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- ImmSrc is purely combinational from op: lw/I-ALU 00, sw 01, beq 10, jal 11, all others 00.
- PCWrite = PCUpdate | (Branch & zero).
- Per-state outputs; any signal not listed is 0:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
    - IRWrite=mem_ready and PCUpdate=mem_ready.
    - Next state DECODE if mem_ready, else stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch target into ALUOut).
    - Next: lw/sw -> MEMADR, R-type -> EXECR, I-ALU -> EXECI, beq -> BEQ, jal -> JAL, other -> FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Next MEMWB when mem_ready, else hold.
  - MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1.
    - MemWrite stays high while waiting; next FETCH on mem_ready.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB.
- ALU decode (internal 2-bit ALUOp):
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10, funct3=000: sub if op[5] & funct7b5, else add.
  - ALUOp 10, other funct3: 010 -> slt, 110 -> or, 111 -> and, any other -> add.
- Latency with mem_ready held high: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready outside those states is ignored.
- Unused state encodings -> FETCH on the next edge.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcode in DECODE -> ERROR state.
  - ERROR asserts illegal=1, holds all strobes 0 and stays until reset.
- Undefined:
  - Unsupported opcode goes DECODE -> FETCH and executes as a 2-cycle NOP.
  - No ERROR state and no illegal port.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings;
  - ALUControl codes.
- One sub-module, alu_decoder: combinational ALUOp/funct3/funct7b5/op[5] -> ALUControl, reused later by the pipelined core.

Test Plan:
- lw (op 0000011), mem_ready=1 -> state_o sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; ImmSrc=00; RegWrite=1 only in cycle 5; ResultSrc=01 there.
- R-type sub (op 0110011, funct3 000, funct7b5 1) -> EXECR ALUControl=001, then ALUWB RegWrite=1. Same with funct7b5 0 -> 000. Same with funct3 111 -> 010.
- beq with zero=1 -> PCWrite=1 in the BEQ cycle. With zero=0 -> PCWrite=0. Both take 3 cycles; ImmSrc=10.
- FETCH with mem_ready=0 for 3 cycles -> state holds, mem_req=1, IRWrite=0. Then mem_ready=1 -> single-cycle IRWrite and PCWrite pulse, then DECODE.
- sw with rst driven low during MEMWRITE, between clock edges -> MemWrite=0 immediately and state_o=FETCH. After release, the fetch sequence restarts.
- op 0000000 -> with ILLEGAL_TRAP_EN: ERROR, illegal=1 held across 10 cycles. Without the macro: returns to FETCH after 2 cycles with no writes.
